// File: rtl/uba_resp_if.sv
// Bus bundle between an initiator and the uba_resp register block.
// The master drives the request side; the slave returns ACK and read data.
interface uba_resp_if;
  logic        busREQI;
  logic        busWRITE;
  logic [17:0] busADDRI;
  logic [35:0] busDATAI;
  logic        busACKO;
  logic [35:0] busDATAO;

  modport master (
    output busREQI, busWRITE, busADDRI, busDATAI,
    input  busACKO, busDATAO
  );

  modport slave (
    input  busREQI, busWRITE, busADDRI, busDATAI,
    output busACKO, busDATAO
  );
endinterface

// File: rtl/uba_resp.sv
// Four-register bus responder: R0-R2 read/write, R3 a read-only transaction
// counter, with programmable wait states and a one-cycle registered ACK.
module uba_resp #(
  parameter logic [17:0] BASEADDR = 18'o763100,
  parameter logic [3:0]  WAITCYC  = 4'd2
) (
  input logic       clk,
  input logic       rst,
  uba_resp_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  idx_q, idx_d;
  logic [35:0] data_q, data_d;
  logic [35:0] r0_q, r0_d;
  logic [35:0] r1_q, r1_d;
  logic [35:0] r2_q, r2_d;
  logic [35:0] r3_q, r3_d;
  logic        ack_q, ack_d;
  logic [35:0] dout_q, dout_d;
  logic        armed_q, armed_d;

  logic [17:0] offset;
  logic        inWindow;

  // Full 18-bit subtraction, so only the four exact addresses hit.
  assign offset   = bus.busADDRI - BASEADDR;
  assign inWindow = (offset[17:2] == 16'd0);

  assign bus.busACKO  = ack_q;
  assign bus.busDATAO = dout_q;

  // armed_q remembers that the request was seen low since the last accept,
  // so a request held across HOLD or reset is never serviced twice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    data_d  = data_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    ack_d   = 1'b0;
    dout_d  = 36'd0;
    armed_d = armed_q | ~bus.busREQI;

    case (state_q)
      ST_IDLE: begin
        if (bus.busREQI && armed_q && inWindow) begin
          write_d = bus.busWRITE;
          idx_d   = offset[1:0];
          data_d  = bus.busDATAI;
          armed_d = 1'b0;
          if (WAITCYC == 4'd0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAITCYC - 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.busREQI) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        ack_d   = 1'b1;
        state_d = ST_HOLD;
        r3_d    = r3_q + 36'd1;
        if (write_q) begin
          case (idx_q)
            2'd0:    r0_d = data_q;
            2'd1:    r1_d = data_q;
            2'd2:    r2_d = data_q;
            default: ;
          endcase
        end else begin
          case (idx_q)
            2'd0:    dout_d = r0_q;
            2'd1:    dout_d = r1_q;
            2'd2:    dout_d = r2_q;
            default: dout_d = r3_q;
          endcase
        end
      end
      default: begin
        if (!bus.busREQI) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      idx_q   <= 2'd0;
      data_q  <= 36'd0;
      r0_q    <= 36'd0;
      r1_q    <= 36'd0;
      r2_q    <= 36'd0;
      r3_q    <= 36'd0;
      ack_q   <= 1'b0;
      dout_q  <= 36'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: tb/tb_uba_resp.sv
// Randomised scoreboard bench for uba_resp: one instance with two wait states
// and one with none, both checked against a register/counter reference model.
module tb_uba_resp;

  localparam logic [17:0] BASE = 18'o763100;
  localparam logic [35:0] ALL1 = 36'o777777777777;

  typedef struct {
    logic [35:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uba_resp_if bus2();
  uba_resp_if bus0();

  logic        req   = 1'b0;
  logic        wr    = 1'b0;
  logic [17:0] addr  = '0;
  logic [35:0] wdata = '0;
  int          sel   = 0;

  assign bus2.busREQI  = (sel == 0) && req;
  assign bus2.busWRITE = wr;
  assign bus2.busADDRI = addr;
  assign bus2.busDATAI = wdata;
  assign bus0.busREQI  = (sel == 1) && req;
  assign bus0.busWRITE = wr;
  assign bus0.busADDRI = addr;
  assign bus0.busDATAI = wdata;

  uba_resp #(.BASEADDR(BASE), .WAITCYC(4'd2)) dut  (.clk(clk), .rst(rst), .bus(bus2));
  uba_resp #(.BASEADDR(BASE), .WAITCYC(4'd0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  int checks   = 0;
  int failures = 0;

  exp_t        expQ0[$];
  exp_t        expQ1[$];
  logic [35:0] mdlReg[2][4];

  function automatic bit inWindow(logic [17:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} <= {1'b0, BASE} + 19'd3);
  endfunction

  function automatic void resetModel();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++)
        mdlReg[i][j] = '0;
    expQ0.delete();
    expQ1.delete();
  endfunction

  // Reference behaviour: reads see the pre-access value, writes to R3 are
  // dropped, and every completed access bumps the counter modulo 2**36.
  function automatic logic [35:0] modelAccess(int inst, bit write, int idx, logic [35:0] d);
    logic [35:0] r;
    r = write ? 36'd0 : mdlReg[inst][idx];
    if (write && idx != 3) mdlReg[inst][idx] = d;
    mdlReg[inst][3] = mdlReg[inst][3] + 36'd1;
    return r;
  endfunction

  function automatic void checkOutput(int inst, logic ack, logic [35:0] dout);
    exp_t e;
    bit   empty;
    empty = (inst == 0) ? (expQ0.size() == 0) : (expQ1.size() == 0);
    if (ack) begin
      checks++;
      if (empty) begin
        failures++;
        $display("[TB] FAIL unexpectedAck inst=%0d actual ack=1 required ack=0 cycle=%0d", inst, cycleCnt);
      end else begin
        e = (inst == 0) ? expQ0.pop_front() : expQ1.pop_front();
        if (dout !== e.data) begin
          failures++;
          $display("[TB] FAIL ackData inst=%0d actual=%o required=%o", inst, dout, e.data);
        end
        checks++;
        if (cycleCnt != e.cyc) begin
          failures++;
          $display("[TB] FAIL ackLatency inst=%0d actual cycle=%0d required cycle=%0d", inst, cycleCnt, e.cyc);
        end
      end
    end else begin
      checks++;
      if (dout !== 36'd0) begin
        failures++;
        $display("[TB] FAIL idleData inst=%0d actual=%o required=0", inst, dout);
      end
    end
  endfunction

  always @(negedge clk) begin
    checkOutput(0, bus2.busACKO, bus2.busDATAO);
    checkOutput(1, bus0.busACKO, bus0.busDATAO);
  end

  function automatic logic ackOf(int inst);
    return (inst == 0) ? bus2.busACKO : bus0.busACKO;
  endfunction

  // One bus transaction from a negedge; in-window accesses push their expected
  // ACK (data and cycle) and wait for it, out-of-window ones just hold.
  task automatic applyStimulus(int inst, bit write, logic [17:0] a, logic [35:0] d, int hold);
    exp_t e;
    bit   got;
    sel   = inst;
    wr    = write;
    addr  = a;
    wdata = d;
    if (inWindow(a)) begin
      e.data = modelAccess(inst, write, int'(a - BASE), d);
      e.cyc  = cycleCnt + ((inst == 0) ? 2 : 0) + 2;
      if (inst == 0) expQ0.push_back(e);
      else           expQ1.push_back(e);
      req = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        got = ackOf(inst);
      end
      checks++;
      if (!got) begin
        failures++;
        $display("[TB] FAIL ackTimeout inst=%0d actual ack=0 required ack=1", inst);
      end
      repeat (hold) @(negedge clk);
    end else begin
      req = 1'b1;
      repeat (hold) @(negedge clk);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic abortTx(logic [17:0] a);
    sel  = 0;
    wr   = 1'b1;
    addr = a;
    wdata = 36'o555555555555;
    req  = 1'b1;
    @(negedge clk);
    req  = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic readAll(int inst);
    for (int i = 0; i < 4; i++) applyStimulus(inst, 1'b0, BASE + 18'(i), '0, 0);
  endtask

  initial begin
    logic [17:0] badAddr[4];
    int          kind;
    int          inst;
    badAddr[0] = BASE + 18'd4;
    badAddr[1] = BASE - 18'd1;
    badAddr[2] = BASE ^ 18'o400000;
    badAddr[3] = BASE ^ 18'o000100;

    resetModel();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    readAll(0);

    applyStimulus(0, 1'b1, BASE + 18'd1, 36'o123456701234, 0);
    applyStimulus(0, 1'b0, BASE + 18'd1, '0, 0);
    applyStimulus(0, 1'b0, BASE + 18'd3, '0, 0);

    applyStimulus(0, 1'b0, BASE + 18'd4, '0, 20);
    abortTx(BASE + 18'd2);
    readAll(0);

    applyStimulus(1, 1'b1, BASE + 18'd3, 36'o1, 0);
    applyStimulus(1, 1'b0, BASE + 18'd3, '0, 0);

    applyStimulus(0, 1'b1, BASE, 36'o7070, 10);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      inst = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if (kind == 0) begin
        abortTx(BASE + 18'($urandom_range(0, 3)));
      end else if (kind == 1) begin
        applyStimulus(inst, 1'($urandom_range(0, 1)), badAddr[$urandom_range(0, 3)],
                      {$urandom, 4'h0}, 6);
      end else begin
        applyStimulus(inst, 1'($urandom_range(0, 1)), BASE + 18'($urandom_range(0, 3)),
                      {$urandom(), $urandom_range(0, 15)}, $urandom_range(0, 3));
      end
    end
    readAll(0);
    readAll(1);

    @(negedge clk);
    force dut.r3_d = ALL1;
    @(negedge clk);
    release dut.r3_d;
    mdlReg[0][3] = ALL1;
    applyStimulus(0, 1'b0, BASE + 18'd3, '0, 0);
    applyStimulus(0, 1'b0, BASE + 18'd3, '0, 0);

    // Reset while the initiator keeps its request up in HOLD.
    sel  = 0;
    wr   = 1'b0;
    addr = BASE + 18'd2;
    begin
      exp_t e;
      e.data = modelAccess(0, 1'b0, 2, '0);
      e.cyc  = cycleCnt + 4;
      expQ0.push_back(e);
    end
    req = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    readAll(0);
    readAll(1);

    checks++;
    if (expQ0.size() != 0 || expQ1.size() != 0) begin
      failures++;
      $display("[TB] FAIL pendingAcks actual=%0d required=0", expQ0.size() + expQ1.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
